// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: the sequencer state encoding and default
// sizing used by the sequencer, decode and debug/trace logic.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_FETCH = 3'b001,
    ST_EXEC1 = 3'b010,
    ST_EXEC2 = 3'b011,
    ST_HALT  = 3'b100,
    ST_ERR   = 3'b101
  } state_e;

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;
  localparam int unsigned CNT_WIDTH_DEFAULT   = 16;
  localparam int unsigned WAIT_WIDTH          = 8;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer (master) and the decode/memory/datapath side (slave).
interface cpu_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 P;
  logic                 EXTRA;
  logic                 MEM_OP;
  logic                 HALT_REQ;
  logic                 MEM_ACK;
  logic                 MEM_REQ;
  logic                 FETCH;
  logic                 EXEC1;
  logic                 EXEC2;
  logic                 ADVANCE;
  logic                 STALL;
  logic                 HALTED;
  logic                 ERROR;
  logic [2:0]           STATE;
  logic [CNT_WIDTH-1:0] INSTR_CNT;

  modport master (
    input  P, EXTRA, MEM_OP, HALT_REQ, MEM_ACK,
    output MEM_REQ, FETCH, EXEC1, EXEC2, ADVANCE, STALL, HALTED, ERROR,
           STATE, INSTR_CNT
  );

  modport slave (
    output P, EXTRA, MEM_OP, HALT_REQ, MEM_ACK,
    input  MEM_REQ, FETCH, EXEC1, EXEC2, ADVANCE, STALL, HALTED, ERROR,
           STATE, INSTR_CNT
  );
endinterface

// File: rtl/cpu_sequencer.sv
// CPU control sequencer: FETCH/EXEC1/EXEC2 phasing with memory handshake,
// run/stop, sticky halt, bus-timeout error and a retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input logic             CLK,
  input logic             RESET,
  cpu_sequencer_if.master bus
);

  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(ACK_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  mem_req_s;
  logic                  stall_s;
  logic                  advance_s;
  logic                  retire_s;

  always_comb begin
    state_d   = state_q;
    mem_req_s = 1'b0;
    advance_s = 1'b0;
    retire_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.P) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        mem_req_s = 1'b1;
        if (bus.MEM_ACK) begin
          advance_s = 1'b1;
          state_d   = ST_EXEC1;
        end else begin
          state_d   = ST_FETCH;
        end
      end
      ST_EXEC1: begin
        mem_req_s = bus.MEM_OP;
        if (!bus.MEM_OP || bus.MEM_ACK) begin
          advance_s = 1'b1;
          // Halt wins over EXTRA; a halting instruction still retires.
          if (bus.HALT_REQ) begin
            retire_s = 1'b1;
            state_d  = ST_HALT;
          end else if (bus.EXTRA) begin
            state_d  = ST_EXEC2;
          end else begin
            retire_s = 1'b1;
            state_d  = bus.P ? ST_FETCH : ST_IDLE;
          end
        end else begin
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC2: begin
        advance_s = 1'b1;
        retire_s  = 1'b1;
        state_d   = bus.P ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    stall_s = mem_req_s & ~bus.MEM_ACK;
    // Not stalling means either no request or an ack that advanced the phase.
    if (stall_s) begin
      wait_d = wait_q + WAIT_WIDTH'(1);
      if (wait_q == WAIT_LAST) state_d = ST_ERR;
      else                     state_d = state_d;
    end else begin
      wait_d = '0;
    end

    if (retire_s) cnt_d = cnt_q + CNT_WIDTH'(1);
    else          cnt_d = cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.MEM_REQ   = mem_req_s;
  assign bus.STALL     = stall_s;
  assign bus.ADVANCE   = advance_s;
  assign bus.FETCH     = (state_q == ST_FETCH);
  assign bus.EXEC1     = (state_q == ST_EXEC1);
  assign bus.EXEC2     = (state_q == ST_EXEC2);
  assign bus.HALTED    = (state_q == ST_HALT);
  assign bus.ERROR     = (state_q == ST_ERR);
  assign bus.STATE     = state_q;
  assign bus.INSTR_CNT = cnt_q;

endmodule
